// File: rtl/ex_muldiv_pkg.sv
// Shared types, op encodings, FSM states and corner-case constants for the
// RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 5;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [ALU_OP_W-1:0]   alu_op_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam alu_op_t INST_NOP    = 8'h00;
    localparam alu_op_t INST_MUL    = 8'h40;
    localparam alu_op_t INST_MULH   = 8'h41;
    localparam alu_op_t INST_MULHSU = 8'h42;
    localparam alu_op_t INST_MULHU  = 8'h43;
    localparam alu_op_t INST_DIV    = 8'h44;
    localparam alu_op_t INST_DIVU   = 8'h45;
    localparam alu_op_t INST_REM    = 8'h46;
    localparam alu_op_t INST_REMU   = 8'h47;

    localparam reg_addr_t NOP_REG_ADDR  = 5'd0;
    localparam logic      WRITE_DISABLE = 1'b0;

    localparam word_t DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam word_t ALL_ONES      = 32'hFFFF_FFFF;
    localparam word_t INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Write-back context held for the duration of an operation
    typedef struct packed {
        alu_op_t   op;
        reg_addr_t wd;
        logic      wreg;
    } md_ctx_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU};
    endfunction

    function automatic logic is_m_op(input alu_op_t op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    function automatic logic is_rem_op(input alu_op_t op);
        return op inside {INST_REM, INST_REMU};
    endfunction

    function automatic logic a_signed(input alu_op_t op);
        return op inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
    endfunction

    function automatic logic b_signed(input alu_op_t op);
        return op inside {INST_MULH, INST_DIV, INST_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle over a
// 64-bit partial remainder, 32 steps counted 31 down to 0.
module div_core
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] rem_q, rem_d;
    word_t               dvsr_q, dvsr_d;
    logic [DATA_W:0]     hi;
    logic [DATA_W:0]     diff;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        // Upper 33 bits of the remainder after the left shift
        hi     = rem_q[2*DATA_W-1:DATA_W-1];
        diff   = hi - {1'b0, dvsr_q};
        done   = busy_q && (cnt_q == '0);
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(DATA_W - 1);
            rem_d  = {{DATA_W{1'b0}}, dividend};
            dvsr_d = divisor;
        end else if (busy_q) begin
            rem_d = diff[DATA_W] ? {hi[DATA_W-1:0], rem_q[DATA_W-2:0], 1'b0}
                                 : {diff[DATA_W-1:0], rem_q[DATA_W-2:0], 1'b1};
            cnt_d = cnt_q - CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = rem_q[DATA_W-1:0];
    assign remainder = rem_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage. Define EX_MUL_1CYC_EN for a
// zero-latency combinational multiplier; otherwise multiplies iterate in CALC.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  stallreq_o
);

    md_state_e state_q, state_d;
    md_ctx_t   ctx_q, ctx_d;
    logic      res_neg_q, res_neg_d;
    logic      rem_neg_q, rem_neg_d;
    logic      byp_q, byp_d;
    word_t     byp_res_q, byp_res_d;

    logic      m_op, a_neg, b_neg, div_zero, div_ovf;
    word_t     a_abs, b_abs, byp_res;
    logic      mul_fast;
    word_t     fast_res, mul_res, calc_res, quot_fix, rem_fix;
    logic      core_start, core_abort, core_done;
    word_t     core_quot, core_rem;

    // Decode of the live ID/EX operation
    always_comb begin
        m_op     = is_m_op(aluop_i);
        a_neg    = a_signed(aluop_i) && reg1_i[DATA_W-1];
        b_neg    = b_signed(aluop_i) && reg2_i[DATA_W-1];
        a_abs    = a_neg ? (~reg1_i + DATA_W'(1)) : reg1_i;
        b_abs    = b_neg ? (~reg2_i + DATA_W'(1)) : reg2_i;
        div_zero = is_div_op(aluop_i) && (reg2_i == '0);
        div_ovf  = is_div_op(aluop_i) && b_signed(aluop_i)
                   && (reg1_i == INT_MIN) && (reg2_i == ALL_ONES);
        if (is_rem_op(aluop_i)) begin
            byp_res = div_zero ? reg1_i : '0;
        end else begin
            byp_res = div_zero ? DIV_ZERO_QUOT : INT_MIN;
        end
    end

`ifdef EX_MUL_1CYC_EN
    logic signed [2*DATA_W-1:0] fast_a, fast_b, fast_p;

    // 33x33 signed product; only the low 64 bits are ever needed
    always_comb begin
        fast_a   = {{DATA_W{a_signed(aluop_i) & reg1_i[DATA_W-1]}}, reg1_i};
        fast_b   = {{DATA_W{b_signed(aluop_i) & reg2_i[DATA_W-1]}}, reg2_i};
        fast_p   = fast_a * fast_b;
        mul_fast = is_mul_op(aluop_i);
        fast_res = (aluop_i == INST_MUL) ? fast_p[DATA_W-1:0]
                                         : fast_p[2*DATA_W-1:DATA_W];
        mul_res  = '0;
    end
`else
    logic [2*DATA_W-1:0] prod_q, prod_d, prod_fix;
    word_t               mcand_q, mcand_d;
    logic [DATA_W:0]     prod_sum;

    // Shift-add on magnitudes, sign applied to the final product
    always_comb begin
        mul_fast = 1'b0;
        fast_res = '0;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        prod_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, mcand_q};
        if ((state_q == MD_IDLE) && is_mul_op(aluop_i)) begin
            prod_d  = {{DATA_W{1'b0}}, b_abs};
            mcand_d = a_abs;
        end else if (state_q == MD_CALC) begin
            prod_d = prod_q[0] ? {prod_sum, prod_q[DATA_W-1:1]}
                               : {1'b0, prod_q[2*DATA_W-1:1]};
        end
        prod_fix = res_neg_q ? (~prod_q + (2*DATA_W)'(1)) : prod_q;
        mul_res  = (ctx_q.op == INST_MUL) ? prod_fix[DATA_W-1:0]
                                          : prod_fix[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end
`endif

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .abort     (core_abort),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (core_done),
        .quotient  (core_quot),
        .remainder (core_rem)
    );

    // Sign fix-up of the iterative result
    always_comb begin
        quot_fix = res_neg_q ? (~core_quot + DATA_W'(1)) : core_quot;
        rem_fix  = rem_neg_q ? (~core_rem + DATA_W'(1)) : core_rem;
        if (is_div_op(ctx_q.op)) begin
            calc_res = is_rem_op(ctx_q.op) ? rem_fix : quot_fix;
        end else begin
            calc_res = mul_res;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        byp_d      = byp_q;
        byp_res_d  = byp_res_q;
        core_start = 1'b0;
        core_abort = 1'b0;
        valid_o    = 1'b0;
        wdata_o    = '0;
        wd_o       = NOP_REG_ADDR;
        wreg_o     = WRITE_DISABLE;
        stallreq_o = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (m_op) begin
                    ctx_d.op   = aluop_i;
                    ctx_d.wd   = wd_i;
                    ctx_d.wreg = wreg_i;
                    res_neg_d  = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    byp_d      = div_zero || div_ovf;
                    byp_res_d  = byp_res;
                    if (mul_fast) begin
                        valid_o = 1'b1;
                        wdata_o = fast_res;
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                    end else if (div_zero || div_ovf) begin
                        stallreq_o = 1'b1;
                        state_d    = MD_DONE;
                    end else begin
                        stallreq_o = 1'b1;
                        core_start = 1'b1;
                        state_d    = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                stallreq_o = 1'b1;
                if (core_done) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                valid_o = 1'b1;
                wdata_o = byp_q ? byp_res_q : calc_res;
                wd_o    = ctx_q.wd;
                wreg_o  = ctx_q.wreg;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // A flushed op is dropped without a result
        if (flush_i) begin
            state_d    = MD_IDLE;
            core_start = 1'b0;
            core_abort = 1'b1;
            valid_o    = 1'b0;
            wdata_o    = '0;
            wd_o       = NOP_REG_ADDR;
            wreg_o     = WRITE_DISABLE;
            stallreq_o = 1'b0;
        end
        if (!rst) begin
            valid_o    = 1'b0;
            wdata_o    = '0;
            wd_o       = NOP_REG_ADDR;
            wreg_o     = WRITE_DISABLE;
            stallreq_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            ctx_q     <= '{op: INST_NOP, wd: NOP_REG_ADDR, wreg: WRITE_DISABLE};
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            byp_q     <= 1'b0;
            byp_res_q <= '0;
        end else begin
            state_q   <= state_d;
            ctx_q     <= ctx_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            byp_q     <= byp_d;
            byp_res_q <= byp_res_d;
        end
    end

endmodule
